uart_tx_fifo: RTL and testbench

- Serial UART transmitter: buffers bytes from a parallel valid/ready source in a small FIFO, then serialises each one on TX.
- Frame format: 8N1, LSB first, idle-high line.
- Pairs with the team's UART receiver on the other end of the link. The default bit period (101 CLK cycles) matches that receiver's sampling timing.
- Sits between the host/controller logic and the board TX pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/uart_tx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver so both ends of the
// link agree on state encoding, bit period and frame length.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_CLKS_PER_BIT = 101;
  localparam int UART_FRAME_BITS   = 10;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags derived from the next
// occupancy, so downstream handshakes come straight from flops.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_ZERO  = CNTW'(0);
  localparam logic [CNTW-1:0] CNT_DEPTH = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNTW-1:0]  count_r;
  logic [CNTW-1:0]  count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the current flags and compute next occupancy.
  always_comb begin
    do_push_s   = push && !full_r;
    do_pop_s    = pop && !empty_r;
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy and flags.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_DEPTH);
      empty_r <= (count_nxt_s == CNT_ZERO);
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign count   = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames run back to back
// whenever the FIFO still holds data at the end of a stop bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       TX,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Data bits are the frame minus start and stop; index of the last one.
  localparam logic [2:0]    LAST_BIT = 3'(UART_FRAME_BITS - 3);

  uart_state_e     state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [2:0]      bit_idx_r, bit_idx_nxt_s;
  logic [7:0]      shift_r, shift_nxt_s;
  logic            tx_r, tx_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            push_s, pop_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [7:0]      fifo_rd_data_s;
  logic [CNTW-1:0] fifo_count_s;

  assign ready  = !fifo_full_s;
  assign push_s = valid && !fifo_full_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .push    (push_s),
    .wr_data (data),
    .pop     (pop_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Frame sequencing: next state, counters, shift register and TX level.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    tx_nxt_s      = tx_r;
    pop_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = fifo_rd_data_s;
          tx_nxt_s    = 1'b0;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = START;
        end else begin
          tx_nxt_s = 1'b1;
        end
      end
      START: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s     = CNT_ZERO;
          tx_nxt_s      = shift_r[0];
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = DATA;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (bit_idx_r == LAST_BIT) begin
            tx_nxt_s    = 1'b1;
            state_nxt_s = STOP;
          end else begin
            shift_nxt_s   = {1'b0, shift_r[7:1]};
            tx_nxt_s      = shift_r[1];
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            shift_nxt_s = fifo_rd_data_s;
            tx_nxt_s    = 1'b0;
            state_nxt_s = START;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        tx_nxt_s    = 1'b1;
      end
    endcase
    // A push this edge makes the FIFO non-empty even though the flag lags.
    busy_nxt_s = (state_nxt_s != IDLE) || (fifo_count_s != CNTW'(0)) || push_s;
  end

  // State register; reset aborts any frame and parks the line high.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      tx_r      <= tx_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign TX   = tx_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default-rate instance for framing, queueing
// and reset; a two-cycle-per-bit instance for the corner case and loopback.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB   = UART_CLKS_PER_BIT;
  localparam int CPB2  = 2;
  localparam int FRAME = UART_FRAME_BITS * CPB;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic [7:0] data, data2;
  logic       valid, valid2;
  logic       ready, TX, busy;
  logic       ready2, tx2, busy2;
  int         checks = 0;
  int         errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_fifo dut (
    .CLK(CLK), .RESETN(RESETN), .data(data), .valid(valid),
    .ready(ready), .TX(TX), .busy(busy)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(4)) dut2 (
    .CLK(CLK), .RESETN(RESETN), .data(data2), .valid(valid2),
    .ready(ready2), .TX(tx2), .busy(busy2)
  );

  // Expected line level at cycle pos of a frame carrying byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int pos, input int cpb);
    int slot;
    slot = pos / cpb;
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return b[slot-1];
    else return 1'b1;
  endfunction

  function automatic logic line_of(input bit sel2);
    return sel2 ? tx2 : TX;
  endfunction

  // Receiver model: call on a negedge; samples each bit at its midpoint.
  task automatic rx_capture(input bit sel2, input int bound, output logic [7:0] b, output bit ok);
    int n;
    int cpb;
    cpb = sel2 ? CPB2 : CPB;
    ok = 1'b0;
    b = 8'h00;
    n = 0;
    while (line_of(sel2) !== 1'b0 && n < bound) begin
      @(negedge CLK);
      n++;
    end
    if (line_of(sel2) !== 1'b0) return;
    repeat (cpb / 2) @(negedge CLK);
    if (line_of(sel2) !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge CLK);
      b[i] = line_of(sel2);
    end
    repeat (cpb) @(negedge CLK);
    ok = (line_of(sel2) === 1'b1);
  endtask

  task automatic test_reset();
    valid = 1'b0; valid2 = 1'b0; data = 8'h00; data2 = 8'h00;
    #2 RESETN = 1'b0;
    #1;
    checks++;
    if (TX !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got TX=%b ready=%b busy=%b want 1 1 0", TX, ready, busy);
    end
    checks++;
    if (tx2 !== 1'b1 || ready2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_cpb2 got TX=%b ready=%b busy=%b want 1 1 0", tx2, ready2, busy2);
    end
    repeat (3) @(negedge CLK);
    RESETN = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (TX !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got TX=%b ready=%b busy=%b want 1 1 0", TX, ready, busy);
    end
  endtask

  task automatic test_single_byte();
    int mism[10];
    int busy_bad;
    busy_bad = 0;
    for (int s = 0; s < 10; s++) mism[s] = 0;
    data = 8'hA5; valid = 1'b1;
    @(negedge CLK);
    valid = 1'b0;
    checks++;
    if (TX !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got TX=%b busy=%b want 1 1", TX, busy);
    end
    for (int p = 0; p < FRAME; p++) begin
      @(negedge CLK);
      if (TX !== exp_tx(8'hA5, p, CPB)) mism[p / CPB]++;
      if (busy !== 1'b1) busy_bad++;
    end
    for (int s = 0; s < 10; s++) begin
      checks++;
      if (mism[s] != 0) begin
        errors++;
        $display("FAIL single_slot%0d got %0d wrong cycles want 0", s, mism[s]);
      end
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL single_busy got %0d low cycles want 0", busy_bad);
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || TX !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL single_end got busy=%b TX=%b ready=%b want 0 1 1", busy, TX, ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int mism[3];
    int busy_bad;
    bytes = '{8'h00, 8'hFF, 8'h55};
    mism = '{0, 0, 0};
    busy_bad = 0;
    data = bytes[0]; valid = 1'b1;
    @(negedge CLK);
    data = bytes[1];
    for (int p = 0; p < 3 * FRAME; p++) begin
      @(negedge CLK);
      if (p == 0) data = bytes[2];
      if (p == 1) valid = 1'b0;
      if (TX !== exp_tx(bytes[p / FRAME], p % FRAME, CPB)) mism[p / FRAME]++;
      if (busy !== 1'b1) busy_bad++;
    end
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (mism[f] != 0) begin
        errors++;
        $display("FAIL b2b_frame%0d got %0d wrong cycles want 0", f, mism[f]);
      end
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL b2b_busy got %0d low cycles want 0", busy_bad);
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || TX !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got busy=%b TX=%b want 0 1", busy, TX);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bp [6];
    logic [7:0] got [6];
    bit         okk [6];
    int         acc;
    int         n;
    bp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    acc = 0;
    n = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) rx_capture(1'b0, 3 * FRAME, got[i], okk[i]);
      end
      begin
        data = bp[0]; valid = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        repeat (10) @(negedge CLK);
        data = bp[1]; valid = 1'b1;
        while (ready === 1'b1 && n < 8) begin
          @(negedge CLK);
          acc++; n++;
          if (acc < 5) data = bp[1 + acc];
        end
        checks++;
        if (acc != 4 || ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_accepts got %0d accepts ready=%b want 4 0", acc, ready);
        end
        n = 0;
        while (ready !== 1'b1 && n < 2 * FRAME) begin
          @(negedge CLK);
          n++;
        end
        // ready went low after edge 14 and returns after the first STOP edge (1011).
        checks++;
        if (n != FRAME + 1 - 14) begin
          errors++;
          $display("FAIL bp_stall got %0d cycles want %0d", n, FRAME + 1 - 14);
        end
        @(negedge CLK);
        valid = 1'b0;
      end
    join
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!okk[i] || got[i] !== bp[i]) begin
        errors++;
        $display("FAIL bp_order%0d got %h framed=%0d want %h", i, got[i], okk[i], bp[i]);
      end
    end
    n = 0;
    while (busy !== 1'b0 && n < 2 * FRAME) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    bad = 0;
    data = 8'h3C; valid = 1'b1;
    @(negedge CLK);
    data = 8'hC3;
    @(negedge CLK);
    data = 8'h7E;
    @(negedge CLK);
    valid = 1'b0;
    // Now at frame cycle 1; advance to the middle of data bit 3.
    repeat (4 * CPB + CPB / 2 - 1) @(negedge CLK);
    checks++;
    if (TX !== exp_tx(8'h3C, 4 * CPB + CPB / 2, CPB) || busy !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got TX=%b busy=%b ready=%b want 1 1 1", TX, busy, ready);
    end
    RESETN = 1'b0;
    #1;
    checks++;
    if (TX !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got TX=%b busy=%b ready=%b want 1 0 1", TX, busy, ready);
    end
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    for (int p = 0; p < 3 * FRAME; p++) begin
      @(negedge CLK);
      if (TX !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_no_frames got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_cpb2_corner();
    int mism;
    int busy_bad;
    mism = 0;
    busy_bad = 0;
    data2 = 8'h81; valid2 = 1'b1;
    @(negedge CLK);
    valid2 = 1'b0;
    checks++;
    if (tx2 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL cpb2_latency got TX=%b busy=%b want 1 1", tx2, busy2);
    end
    for (int p = 0; p < UART_FRAME_BITS * CPB2; p++) begin
      @(negedge CLK);
      if (tx2 !== exp_tx(8'h81, p, CPB2)) mism++;
      if (busy2 !== 1'b1) busy_bad++;
    end
    checks++;
    if (mism != 0 || busy_bad != 0) begin
      errors++;
      $display("FAIL cpb2_frame got %0d wrong TX %0d low busy want 0 0", mism, busy_bad);
    end
    @(negedge CLK);
    checks++;
    if (busy2 !== 1'b0 || tx2 !== 1'b1) begin
      errors++;
      $display("FAIL cpb2_end got busy=%b TX=%b want 0 1", busy2, tx2);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    bit         ok;
    int         n;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          rx_capture(1'b1, 100, b, ok);
          checks++;
          if (!ok || b !== 8'(i)) begin
            errors++;
            $display("FAIL loopback%0d got %h framed=%0d want %h", i, b, ok, 8'(i));
          end
        end
      end
      begin
        for (int i = 0; i < 256; i++) begin
          data2 = 8'(i); valid2 = 1'b1;
          n = 0;
          while (ready2 !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
          end
          @(negedge CLK);
        end
        valid2 = 1'b0;
      end
    join
  endtask

  initial begin
    test_reset();
    test_single_byte();
    repeat (5) @(negedge CLK);
    test_back_to_back();
    repeat (5) @(negedge CLK);
    test_backpressure();
    repeat (5) @(negedge CLK);
    test_reset_mid_frame();
    test_cpb2_corner();
    repeat (3) @(negedge CLK);
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
